// File: rtl/tsq_rgs_pkg.sv
// Shared definitions for the timestamp-queue register bank.
// Holds the register map offsets, the STAT word bit positions, the CTRL
// reset-field shift and the per-channel read sequencer state encoding.
package tsq_rgs_pkg;

  // Register map (byte offsets).
  localparam int unsigned CTRL_OFS     = 32'h00;
  localparam int unsigned IRQ_MASK_OFS = 32'h04;
  localparam int unsigned IRQ_STAT_OFS = 32'h08;
  localparam int unsigned CH_BASE      = 32'h10;
  localparam int unsigned CH_STRIDE    = 32'h10;
  localparam int unsigned STAT_OFS     = 32'h0;
  localparam int unsigned DHI_OFS      = 32'h4;
  localparam int unsigned DLO_OFS      = 32'h8;

  // CTRL: pop request in bit c, queue reset in bit CTRL_RST_SHIFT+c.
  localparam int unsigned CTRL_RST_SHIFT = 8;

  // Channel STAT word bit positions.
  localparam int unsigned STAT_BUSY_BIT  = 31;
  localparam int unsigned STAT_OK_BIT    = 30;
  localparam int unsigned STAT_ERR_BIT   = 29;
  localparam int unsigned STAT_EMPTY_BIT = 28;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_POP  = 2'd1,
    SEQ_WAIT = 2'd2,
    SEQ_CAP  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/tsq_rgs_rd_seq.sv
// One channel's read sequencer: pops a queue entry, waits out the queue
// read latency, captures the head data into a 64-bit holding register.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   pop_req    pop command pulse (already masked by a same-write queue reset)
//   q_rst_req  queue reset command pulse; aborts the channel
//   q_empty    queue empty flag
//   q_data     queue head data
//   q_rd_en    one-cycle pop pulse to the queue
//   busy/ok/err channel status flags
//   hold       captured entry, zero-extended to 64 bits
//   cap_done   high in the cycle whose closing edge performs the capture
module tsq_rd_seq
  import tsq_rgs_pkg::*;
#(
  parameter int unsigned Q_DATA_W = 64,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pop_req,
  input  logic                q_rst_req,
  input  logic                q_empty,
  input  logic [Q_DATA_W-1:0] q_data,
  output logic                q_rd_en,
  output logic                busy,
  output logic                ok,
  output logic                err,
  output logic [63:0]         hold,
  output logic                cap_done
);

  // WAIT dwells RD_LAT-1 cycles; RD_LAT==1 skips WAIT entirely.
  localparam logic [1:0] CNT_INIT = 2'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  seq_state_e state, state_nx;
  logic [1:0] cnt;
  logic       accept, reject;

  assign accept = (state == SEQ_IDLE) && pop_req && !q_empty;
  assign reject = (state == SEQ_IDLE) && pop_req && q_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEQ_IDLE;
      cnt   <= '0;
      hold  <= '0;
      ok    <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (q_rst_req) begin
        cnt  <= '0;
        hold <= '0;
        ok   <= 1'b0;
        err  <= 1'b0;
      end else begin
        if (accept) begin
          ok  <= 1'b0;
          err <= 1'b0;
        end else if (reject) begin
          err <= 1'b1;
        end
        if (state == SEQ_POP) begin
          cnt <= CNT_INIT;
        end else if ((state == SEQ_WAIT) && (cnt != '0)) begin
          cnt <= cnt - 2'd1;
        end
        if (state == SEQ_CAP) begin
          hold <= 64'(q_data);
          ok   <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    if (q_rst_req) begin
      state_nx = SEQ_IDLE;
    end else begin
      case (state)
        SEQ_IDLE: if (accept) state_nx = SEQ_POP;
        SEQ_POP:  state_nx = (RD_LAT > 1) ? SEQ_WAIT : SEQ_CAP;
        SEQ_WAIT: if (cnt == '0) state_nx = SEQ_CAP;
        SEQ_CAP:  state_nx = SEQ_IDLE;
        default:  state_nx = SEQ_IDLE;
      endcase
    end
  end

  always_comb begin
    q_rd_en  = (state == SEQ_POP);
    busy     = (state != SEQ_IDLE);
    cap_done = (state == SEQ_CAP) && !q_rst_req;
  end

endmodule

// File: rtl/tsq_rgs.sv
// Register bank and read sequencer for NUM_Q timestamp queues.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_in, rd_in      bus write / read strobes
//   addr_in           byte address (bits [1:0] ignored)
//   data_in           write data
//   data_out          registered read data, held between reads
//   rd_valid_out      data_out valid, one cycle after rd_in
//   q_rst_out         per-channel queue reset pulse
//   q_rd_en_out       per-channel queue pop pulse
//   q_empty_in        per-channel queue empty flag
//   q_stat_in         packed per-channel queue fill status, ch0 in LSBs
//   q_data_in         packed per-channel queue head data, ch0 in LSBs
//   irq_out           registered |(IRQ_STAT & IRQ_MASK)
module tsq_rgs
  import tsq_rgs_pkg::*;
#(
  parameter int unsigned NUM_Q    = 2,
  parameter int unsigned Q_DATA_W = 64,
  parameter int unsigned Q_STAT_W = 8,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned ADDR_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_in,
  input  logic                         rd_in,
  input  logic [ADDR_W-1:0]            addr_in,
  input  logic [31:0]                  data_in,
  output logic [31:0]                  data_out,
  output logic                         rd_valid_out,
  output logic [NUM_Q-1:0]             q_rst_out,
  output logic [NUM_Q-1:0]             q_rd_en_out,
  input  logic [NUM_Q-1:0]             q_empty_in,
  input  logic [NUM_Q*Q_STAT_W-1:0]    q_stat_in,
  input  logic [NUM_Q*Q_DATA_W-1:0]    q_data_in,
  output logic                         irq_out
);

  logic [31:0]      addr_w;
  logic [31:0]      ch_off;
  logic [31:0]      ch_idx;
  logic [31:0]      reg_off;
  logic             ctrl_wr, mask_wr, stat_wr;
  logic [NUM_Q-1:0] pop_req, qrst_req;
  logic [NUM_Q-1:0] busy, ok, err, cap_done;
  logic [63:0]      hold [NUM_Q];
  logic [31:0]      stat_word [NUM_Q];
  logic [NUM_Q-1:0] irq_mask, irq_stat, stat_nx;
  logic [31:0]      rd_data;
  logic             unused_data_bits;

  // Only the low command/mask bits of data_in carry meaning.
  assign unused_data_bits = ^data_in;

  assign addr_w  = 32'(addr_in & ~ADDR_W'(3));
  assign ch_off  = addr_w - CH_BASE;
  assign ch_idx  = ch_off / CH_STRIDE;
  assign reg_off = ch_off % CH_STRIDE;

  assign ctrl_wr = wr_in && (addr_w == CTRL_OFS);
  assign mask_wr = wr_in && (addr_w == IRQ_MASK_OFS);
  assign stat_wr = wr_in && (addr_w == IRQ_STAT_OFS);

  for (genvar g = 0; g < NUM_Q; g++) begin : g_ch
    // A queue reset in the same write suppresses the pop.
    assign qrst_req[g] = ctrl_wr && data_in[CTRL_RST_SHIFT+g];
    assign pop_req[g]  = ctrl_wr && data_in[g] && !qrst_req[g];

    tsq_rd_seq #(
      .Q_DATA_W (Q_DATA_W),
      .RD_LAT   (RD_LAT)
    ) u_seq (
      .clk       (clk),
      .rst       (rst),
      .pop_req   (pop_req[g]),
      .q_rst_req (qrst_req[g]),
      .q_empty   (q_empty_in[g]),
      .q_data    (q_data_in[g*Q_DATA_W +: Q_DATA_W]),
      .q_rd_en   (q_rd_en_out[g]),
      .busy      (busy[g]),
      .ok        (ok[g]),
      .err       (err[g]),
      .hold      (hold[g]),
      .cap_done  (cap_done[g])
    );

    always_comb begin
      stat_word[g]                 = '0;
      stat_word[g][STAT_BUSY_BIT]  = busy[g];
      stat_word[g][STAT_OK_BIT]    = ok[g];
      stat_word[g][STAT_ERR_BIT]   = err[g];
      stat_word[g][STAT_EMPTY_BIT] = q_empty_in[g];
      stat_word[g][15:0]           = 16'(q_stat_in[g*Q_STAT_W +: Q_STAT_W]);
    end
  end

  // W1C first, then capture sets win, then a queue reset clears outright.
  always_comb begin
    stat_nx = irq_stat;
    if (stat_wr) stat_nx = stat_nx & ~data_in[NUM_Q-1:0];
    stat_nx = (stat_nx | cap_done) & ~qrst_req;
  end

  always_comb begin
    rd_data = '0;
    if (addr_w == IRQ_MASK_OFS) begin
      rd_data = 32'(irq_mask);
    end else if (addr_w == IRQ_STAT_OFS) begin
      rd_data = 32'(irq_stat);
    end else if (addr_w >= CH_BASE) begin
      for (int unsigned c = 0; c < NUM_Q; c++) begin
        if (ch_idx == c) begin
          case (reg_off)
            STAT_OFS: rd_data = stat_word[c];
            DHI_OFS:  rd_data = hold[c][63:32];
            DLO_OFS:  rd_data = hold[c][31:0];
            default:  rd_data = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_mask     <= '0;
      irq_stat     <= '0;
      irq_out      <= 1'b0;
      q_rst_out    <= '0;
      rd_valid_out <= 1'b0;
      data_out     <= '0;
    end else begin
      if (mask_wr) irq_mask <= data_in[NUM_Q-1:0];
      irq_stat     <= stat_nx;
      irq_out      <= |(irq_stat & irq_mask);
      q_rst_out    <= qrst_req;
      rd_valid_out <= rd_in;
      if (rd_in) data_out <= rd_data;
    end
  end

endmodule

// File: tb/tb_tsq_rgs.sv
module tb_tsq_rgs;

  localparam int unsigned NUM_Q    = 2;
  localparam int unsigned Q_DATA_W = 64;
  localparam int unsigned Q_STAT_W = 8;
  localparam int unsigned RD_LAT   = 2;
  localparam int unsigned ADDR_W   = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      wr_in, rd_in;
  logic [ADDR_W-1:0]         addr_in;
  logic [31:0]               data_in;
  logic [31:0]               data_out;
  logic                      rd_valid_out;
  logic [NUM_Q-1:0]          q_rst_out, q_rd_en_out, q_empty_in;
  logic [NUM_Q*Q_STAT_W-1:0] q_stat_in;
  logic [NUM_Q*Q_DATA_W-1:0] q_data_in;
  logic                      irq_out;

  tsq_rgs #(
    .NUM_Q    (NUM_Q),
    .Q_DATA_W (Q_DATA_W),
    .Q_STAT_W (Q_STAT_W),
    .RD_LAT   (RD_LAT),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_in        (wr_in),
    .rd_in        (rd_in),
    .addr_in      (addr_in),
    .data_in      (data_in),
    .data_out     (data_out),
    .rd_valid_out (rd_valid_out),
    .q_rst_out    (q_rst_out),
    .q_rd_en_out  (q_rd_en_out),
    .q_empty_in   (q_empty_in),
    .q_stat_in    (q_stat_in),
    .q_data_in    (q_data_in),
    .irq_out      (irq_out)
  );

  always #5 clk = ~clk;

  // Queue side stimulus
  logic [63:0]         qd [NUM_Q];
  logic [Q_STAT_W-1:0] qs [NUM_Q];
  logic                qe [NUM_Q];

  always_comb begin
    q_data_in  = '0;
    q_stat_in  = '0;
    q_empty_in = '0;
    for (int c = 0; c < NUM_Q; c++) begin
      q_data_in[c*Q_DATA_W +: Q_DATA_W] = qd[c][Q_DATA_W-1:0];
      q_stat_in[c*Q_STAT_W +: Q_STAT_W] = qs[c];
      q_empty_in[c]                     = qe[c];
    end
  end

  // Reference model state (register-map view)
  logic             m_ok   [NUM_Q];
  logic             m_err  [NUM_Q];
  logic [63:0]      m_hold [NUM_Q];
  logic [NUM_Q-1:0] m_mask, m_stat;
  int               exp_rd_en [NUM_Q];
  int               exp_rst   [NUM_Q];
  int               rd_en_cnt [NUM_Q];
  int               rst_cnt   [NUM_Q];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } rd_exp_t;
  rd_exp_t rdq [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pulse counters and read scoreboard
  always @(negedge clk) begin : mon
    rd_exp_t e;
    for (int c = 0; c < NUM_Q; c++) begin
      if (q_rd_en_out[c] === 1'b1) rd_en_cnt[c]++;
      if (q_rst_out[c] === 1'b1)   rst_cnt[c]++;
    end
    if (rd_valid_out === 1'b1) begin
      if (rdq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rd_valid: got data %h expected no read", data_out);
      end else begin
        e = rdq.pop_front();
        chk($sformatf("read_%02h", e.addr), 64'(data_out), 64'(e.exp));
      end
    end
  end

  function automatic logic [31:0] stat_word(input int c, input logic b, input logic o,
                                            input logic er);
    return {b, o, er, qe[c], 12'd0, 16'(qs[c])};
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [31:0] aw;
    int          ch;
    int          off;
    aw = a & ~32'd3;
    if (aw == 32'h04) return 32'(m_mask);
    if (aw == 32'h08) return 32'(m_stat);
    if (aw < 32'h10) return 32'd0;
    ch  = int'((aw - 32'h10) / 32'h10);
    off = int'((aw - 32'h10) % 32'h10);
    if (ch >= NUM_Q) return 32'd0;
    case (off)
      0:       return stat_word(ch, 1'b0, m_ok[ch], m_err[ch]);
      4:       return m_hold[ch][63:32];
      8:       return m_hold[ch][31:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_ctrl(input logic [31:0] d);
    for (int c = 0; c < NUM_Q; c++) begin
      if (d[8+c]) begin
        m_ok[c] = 1'b0; m_err[c] = 1'b0; m_hold[c] = '0;
        m_stat[c] = 1'b0; exp_rst[c]++;
      end else if (d[c]) begin
        if (qe[c]) m_err[c] = 1'b1;
        else begin
          m_ok[c] = 1'b1; m_err[c] = 1'b0; m_hold[c] = qd[c];
          m_stat[c] = 1'b1; exp_rd_en[c]++;
        end
      end
    end
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NUM_Q; c++) begin
      m_ok[c] = 1'b0; m_err[c] = 1'b0; m_hold[c] = '0;
    end
    m_mask = '0;
    m_stat = '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr_in = a[ADDR_W-1:0]; data_in = d; wr_in = 1'b1;
    tick();
    wr_in = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] e);
    rdq.push_back('{a, e});
    addr_in = a[ADDR_W-1:0]; rd_in = 1'b1;
    tick();
    rd_in = 1'b0;
  endtask

  task automatic settle();
    repeat (RD_LAT + 3) tick();
  endtask

  task automatic check_settled();
    for (int c = 0; c < NUM_Q; c++) begin
      chk($sformatf("rd_en_count_ch%0d", c), 64'(rd_en_cnt[c]), 64'(exp_rd_en[c]));
      chk($sformatf("q_rst_count_ch%0d", c), 64'(rst_cnt[c]), 64'(exp_rst[c]));
    end
    chk("irq_out", 64'(irq_out), 64'(|(m_stat & m_mask)));
  endtask

  task automatic ctrl_op(input logic [31:0] d);
    model_ctrl(d);
    bus_write(32'h00, d);
    settle();
    check_settled();
  endtask

  task automatic rand_queues();
    for (int c = 0; c < NUM_Q; c++) begin
      qd[c] = {$urandom, $urandom};
      qs[c] = Q_STAT_W'($urandom);
      qe[c] = ($urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] d;
    int          op;
    logic [31:0] a;

    rst = 1'b1; wr_in = 1'b0; rd_in = 1'b0; addr_in = '0; data_in = '0;
    for (int c = 0; c < NUM_Q; c++) begin
      qd[c] = '0; qs[c] = Q_STAT_W'(8'h30 + c); qe[c] = 1'b0;
      exp_rd_en[c] = 0; exp_rst[c] = 0;
    end
    model_reset();
    repeat (4) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid_out), 64'd0);
    chk("rst_q_rst_out", 64'(q_rst_out), 64'd0);
    chk("rst_q_rd_en", 64'(q_rd_en_out), 64'd0);
    chk("rst_irq_out", 64'(irq_out), 64'd0);
    for (int c = 0; c < NUM_Q; c++) bus_read(32'h10 + 32'(c) * 32'h10, 32'(8'h30 + c));
    bus_read(32'h04, 32'd0);
    bus_read(32'h08, 32'd0);

    // Pop on ch1 with full latency trace
    qd[1] = 64'h1234_5678_9ABC_DEF0;
    model_ctrl(32'h02);
    bus_write(32'h00, 32'h02);
    chk("pop_rd_en_pulse", 64'(q_rd_en_out[1]), 64'd1);
    for (int k = 0; k < RD_LAT + 1; k++) begin
      bus_read(32'h20, stat_word(1, 1'b1, 1'b0, 1'b0));
      if (k == 0) chk("pop_rd_en_single", 64'(q_rd_en_out[1]), 64'd0);
    end
    bus_read(32'h20, exp_read(32'h20));
    bus_read(32'h24, 32'h1234_5678);
    bus_read(32'h28, 32'h9ABC_DEF0);
    bus_read(32'h08, 32'h2);
    settle();
    check_settled();

    // Pop while empty
    qe[0] = 1'b1;
    ctrl_op(32'h01);
    bus_read(32'h10, exp_read(32'h10));
    qe[0] = 1'b0;

    // Second pop while busy is ignored
    model_ctrl(32'h01);
    bus_write(32'h00, 32'h01);
    bus_write(32'h00, 32'h01);
    settle();
    check_settled();
    bus_read(32'h10, exp_read(32'h10));

    // Reset wins over pop in the same write
    model_ctrl(32'h101);
    bus_write(32'h00, 32'h101);
    chk("qrst_pulse", 64'(q_rst_out[0]), 64'd1);
    chk("qrst_no_pop", 64'(q_rd_en_out[0]), 64'd0);
    tick();
    chk("qrst_pulse_end", 64'(q_rst_out[0]), 64'd0);
    settle();
    check_settled();
    bus_read(32'h10, exp_read(32'h10));
    bus_read(32'h08, exp_read(32'h08));

    // IRQ: mask, capture, plain W1C, W1C colliding with capture
    m_mask = 1;
    bus_write(32'h04, 32'h1);
    ctrl_op(32'h01);
    chk("irq_after_capture", 64'(irq_out), 64'd1);
    m_stat[0] = 1'b0;
    bus_write(32'h08, 32'h1);
    chk("irq_w1c_lag", 64'(irq_out), 64'd1);
    tick();
    chk("irq_w1c_clear", 64'(irq_out), 64'd0);
    model_ctrl(32'h01);
    bus_write(32'h00, 32'h01);
    repeat (RD_LAT) tick();
    bus_write(32'h08, 32'h1);
    settle();
    check_settled();
    bus_read(32'h08, exp_read(32'h08));

    // Bus checks
    bus_read(32'h90, 32'd0);
    bus_read(32'h30, 32'd0);
    bus_read(32'h1C, 32'd0);
    bus_read(32'h00, 32'd0);
    bus_read(32'h0C, 32'd0);
    rdq.push_back('{32'h04, 32'(m_mask)});
    addr_in = 8'h04; data_in = 32'h2; wr_in = 1'b1; rd_in = 1'b1;
    tick();
    wr_in = 1'b0; rd_in = 1'b0;
    m_mask = 2;
    bus_read(32'h04, 32'h2);
    chk("rd_valid_high", 64'(rd_valid_out), 64'd1);
    tick();
    chk("rd_valid_one_cycle", 64'(rd_valid_out), 64'd0);
    chk("data_out_hold", 64'(data_out), 64'(m_mask));
    settle();
    check_settled();

    // Randomised operations
    for (int it = 0; it < 60; it++) begin
      rand_queues();
      op = int'($urandom_range(0, 4));
      case (op)
        0, 1: begin
          d = '0;
          for (int c = 0; c < NUM_Q; c++) begin
            d[c]   = 1'($urandom_range(0, 1));
            d[8+c] = ($urandom_range(0, 3) == 0);
          end
          ctrl_op(d);
        end
        2: begin
          d = $urandom;
          m_mask = d[NUM_Q-1:0];
          bus_write(32'h04, d);
          settle();
          check_settled();
        end
        3: begin
          d = $urandom;
          m_stat = m_stat & ~d[NUM_Q-1:0];
          bus_write(32'h08, d);
          settle();
          check_settled();
        end
        default: begin
          a = 32'($urandom_range(0, 255));
          bus_read(a, exp_read(a));
        end
      endcase
      a = 32'h10 + 32'($urandom_range(0, NUM_Q - 1)) * 32'h10 + 32'($urandom_range(0, 2)) * 32'h4;
      bus_read(a, exp_read(a));
    end

    // Global reset mid-operation
    qe[1] = 1'b0;
    model_ctrl(32'h02);
    bus_write(32'h00, 32'h02);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    settle();
    check_settled();
    for (int c = 0; c < NUM_Q; c++) begin
      a = 32'h10 + 32'(c) * 32'h10;
      bus_read(a, exp_read(a));
      bus_read(a + 32'h8, 32'd0);
    end

    repeat (3) tick();
    chk("read_queue_drained", 64'(rdq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
